// File: rtl/id_ex_reg.sv
// ID/EX pipeline register: captures decoder controls and ID operands for EX.
// Handles stall (hold), flush (bubble) and squashing of unsupported opcodes.
module id_ex_reg #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 5,
  parameter int unsigned AOP_W  = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              flush,
  input  logic [5:0]        id_opcode,
  input  logic              id_regds,
  input  logic              id_branch,
  input  logic              id_mread,
  input  logic              id_mtor,
  input  logic [AOP_W-1:0]  id_aop,
  input  logic              id_mwrite,
  input  logic              id_alusrc,
  input  logic              id_urw,
  input  logic [DATA_W-1:0] id_rd1,
  input  logic [DATA_W-1:0] id_rd2,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [DATA_W-1:0] id_pc4,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  output logic              ex_regds,
  output logic              ex_branch,
  output logic              ex_mread,
  output logic              ex_mtor,
  output logic [AOP_W-1:0]  ex_aop,
  output logic              ex_mwrite,
  output logic              ex_alusrc,
  output logic              ex_urw,
  output logic [DATA_W-1:0] ex_rd1,
  output logic [DATA_W-1:0] ex_rd2,
  output logic [DATA_W-1:0] ex_imm,
  output logic [DATA_W-1:0] ex_pc4,
  output logic [REG_AW-1:0] ex_rt,
  output logic [REG_AW-1:0] ex_rd,
  output logic              ex_valid,
  output logic              ex_illegal
);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;

  logic legal_c;
  logic dc_clr_c;
  logic squash_c;

  logic              nxt_regds;
  logic              nxt_branch;
  logic              nxt_mread;
  logic              nxt_mtor;
  logic [AOP_W-1:0]  nxt_aop;
  logic              nxt_mwrite;
  logic              nxt_alusrc;
  logic              nxt_urw;
  logic [DATA_W-1:0] nxt_rd1;
  logic [DATA_W-1:0] nxt_rd2;
  logic [DATA_W-1:0] nxt_imm;
  logic [DATA_W-1:0] nxt_pc4;
  logic [REG_AW-1:0] nxt_rt;
  logic [REG_AW-1:0] nxt_rd;
  logic              nxt_valid;
  logic              nxt_illegal;

  // Opcode legality and decoder don't-care clearing for SW/BEQ
  always_comb begin
    legal_c = 1'b0;
    case (id_opcode)
      OP_R, OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_LW, OP_SW, OP_BEQ: legal_c = 1'b1;
      default: legal_c = 1'b0;
    endcase
    dc_clr_c = (id_opcode == OP_SW) || (id_opcode == OP_BEQ);
    squash_c = flush || (en && !legal_c);
  end

  // Next-state selection: flush/illegal bubble > stall hold > legal load
  always_comb begin
    nxt_regds   = ex_regds;
    nxt_branch  = ex_branch;
    nxt_mread   = ex_mread;
    nxt_mtor    = ex_mtor;
    nxt_aop     = ex_aop;
    nxt_mwrite  = ex_mwrite;
    nxt_alusrc  = ex_alusrc;
    nxt_urw     = ex_urw;
    nxt_rd1     = ex_rd1;
    nxt_rd2     = ex_rd2;
    nxt_imm     = ex_imm;
    nxt_pc4     = ex_pc4;
    nxt_rt      = ex_rt;
    nxt_rd      = ex_rd;
    nxt_valid   = ex_valid;
    nxt_illegal = 1'b0;
    if (squash_c) begin
      nxt_regds   = 1'b0;
      nxt_branch  = 1'b0;
      nxt_mread   = 1'b0;
      nxt_mtor    = 1'b0;
      nxt_aop     = '0;
      nxt_mwrite  = 1'b0;
      nxt_alusrc  = 1'b0;
      nxt_urw     = 1'b0;
      nxt_rd1     = '0;
      nxt_rd2     = '0;
      nxt_imm     = '0;
      nxt_pc4     = '0;
      nxt_rt      = '0;
      nxt_rd      = '0;
      nxt_valid   = 1'b0;
      nxt_illegal = !flush;
    end else if (en) begin
      nxt_regds   = id_regds & ~dc_clr_c;
      nxt_branch  = id_branch;
      nxt_mread   = id_mread;
      nxt_mtor    = id_mtor & ~dc_clr_c;
      nxt_aop     = id_aop;
      nxt_mwrite  = id_mwrite;
      nxt_alusrc  = id_alusrc;
      nxt_urw     = id_urw;
      nxt_rd1     = id_rd1;
      nxt_rd2     = id_rd2;
      nxt_imm     = id_imm;
      nxt_pc4     = id_pc4;
      nxt_rt      = id_rt;
      nxt_rd      = id_rd;
      nxt_valid   = 1'b1;
    end
  end

  // Pipeline flops with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_regds   <= 1'b0;
      ex_branch  <= 1'b0;
      ex_mread   <= 1'b0;
      ex_mtor    <= 1'b0;
      ex_aop     <= '0;
      ex_mwrite  <= 1'b0;
      ex_alusrc  <= 1'b0;
      ex_urw     <= 1'b0;
      ex_rd1     <= '0;
      ex_rd2     <= '0;
      ex_imm     <= '0;
      ex_pc4     <= '0;
      ex_rt      <= '0;
      ex_rd      <= '0;
      ex_valid   <= 1'b0;
      ex_illegal <= 1'b0;
    end else begin
      ex_regds   <= nxt_regds;
      ex_branch  <= nxt_branch;
      ex_mread   <= nxt_mread;
      ex_mtor    <= nxt_mtor;
      ex_aop     <= nxt_aop;
      ex_mwrite  <= nxt_mwrite;
      ex_alusrc  <= nxt_alusrc;
      ex_urw     <= nxt_urw;
      ex_rd1     <= nxt_rd1;
      ex_rd2     <= nxt_rd2;
      ex_imm     <= nxt_imm;
      ex_pc4     <= nxt_pc4;
      ex_rt      <= nxt_rt;
      ex_rd      <= nxt_rd;
      ex_valid   <= nxt_valid;
      ex_illegal <= nxt_illegal;
    end
  end

endmodule
